// File: rtl/cnn_window_gen.sv
// 3x3 neighbourhood generator: two column-indexed line buffers feed three
// column shift registers whose contents form the registered output window.
module cnn_window_gen #(
    parameter int DW        = 8,
    parameter int W_SIZE    = 12,
    parameter int MAX_WIDTH = 128
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [W_SIZE-1:0] q_width,
    input  logic              i_data_run,
    input  logic [W_SIZE-1:0] i_row,
    input  logic [W_SIZE-1:0] i_col,
    input  logic [DW-1:0]     i_pixel,
    input  logic              i_end_frame,
    output logic              o_valid,
    output logic [9*DW-1:0]   o_window,
    output logic [W_SIZE-1:0] o_row,
    output logic [W_SIZE-1:0] o_col,
    output logic              o_end_frame
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [W_SIZE-1:0] MAXW = W_SIZE'(MAX_WIDTH);

    logic [DW-1:0] lb0_q [MAX_WIDTH];
    logic [DW-1:0] lb1_q [MAX_WIDTH];

    logic [8:0][DW-1:0] win_q, win_d;
    logic [2:0][DW-1:0] tap;
    logic               valid_q, eof_q;
    logic [W_SIZE-1:0]  row_q, col_q;
    logic               in_range;
    logic [AW-1:0]      addr;

    // Frame width is implied by the controller's column indices.
    logic unused_q_width;
    assign unused_q_width = ^q_width;

    assign in_range = (i_col < MAXW);
    assign addr     = i_col[AW-1:0];

    // Row masking keeps stale line-buffer contents out of the window.
    always_comb begin
        tap[2] = i_pixel;
        tap[1] = '0;
        tap[0] = '0;
        if (in_range && (i_row != '0))
            tap[1] = lb0_q[addr];
        if (in_range && (i_row >= W_SIZE'(2)))
            tap[0] = lb1_q[addr];
    end

    always_comb begin
        win_d = win_q;
        if (i_data_run) begin
            for (int i = 0; i < 3; i++) begin
                win_d[3*i+0] = (i_col == '0) ? '0 : win_q[3*i+1];
                win_d[3*i+1] = (i_col == '0) ? '0 : win_q[3*i+2];
                win_d[3*i+2] = tap[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_data_run && in_range) begin
            lb1_q[addr] <= lb0_q[addr];
            lb0_q[addr] <= i_pixel;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_q   <= '0;
            valid_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            eof_q   <= 1'b0;
        end else begin
            win_q   <= win_d;
            valid_q <= i_data_run;
            eof_q   <= i_end_frame;
            if (i_data_run) begin
                row_q <= i_row;
                col_q <= i_col;
            end
        end
    end

    assign o_valid     = valid_q;
    assign o_window    = win_q;
    assign o_row       = row_q;
    assign o_col       = col_q;
    assign o_end_frame = eof_q;

endmodule
